dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the single-cycle datapath's load/store port. It accepts a request built from the datapath's ALU_out (address), Data_out (store data) and the instruction's funct3, then services it from an internal word-organised RAM after a programmable wait-state latency.
- It returns the sign- or zero-extended load data that the datapath consumes as Data_in.
- It uses a valid/ready handshake on both the request and the response sides, and it is the reference memory model for the multi-cycle CPU variants.

Parameters:
- ADDR_WIDTH, 10, number of word-index bits; the RAM holds 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, extra wait-state cycles before an access completes (0..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  access type; RISC-V load/store funct3 encoding.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (bits [7:0] for a byte store).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  access rejected (misaligned or illegal funct3).

Behaviour:
- Reset values:
  - Reset forces state IDLE and the wait counter to 0.
  - Outputs after reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - RAM contents are not cleared.
  - Reset during BUSY or RESP abandons the transaction: no write occurs and the response is dropped.
- FSM states: IDLE, BUSY, RESP.
  - req_ready = (state==IDLE). rsp_valid = (state==RESP).
- IDLE:
  - On req_valid, at the edge, latch we, funct3, addr and wdata, load counter=WAIT_CYCLES, and go to BUSY.
- BUSY:
  - On each edge, if counter != 0, decrement the counter.
  - Otherwise, perform the access: write the RAM or register the read result, set rsp_rdata and rsp_err, and go to RESP.
  - Latency: rsp_valid rises WAIT_CYCLES+1 edges after the accepting edge.
  - Inputs are ignored while in BUSY.
- RESP:
  - rsp_rdata and rsp_err hold stable until an edge with rsp_ready=1; that edge moves the FSM to IDLE.
  - A new request cannot be accepted in the same cycle as the response handoff; the minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- Addressing:
  - Word index = addr[ADDR_WIDTH+1:2]; higher address bits are ignored, so accesses wrap.
  - Byte lane = addr[1:0].
- Legal funct3 values:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other code sets rsp_err=1.
- Alignment:
  - Halfword accesses require addr[0]=0; word accesses require addr[1:0]=00.
  - A violation sets rsp_err=1.
- Error responses:
  - The RAM is not modified and rsp_rdata=0.
  - Latency is identical to a successful access.
- Stores:
  - Only the addressed lanes are written. sb writes lane addr[1:0] with wdata[7:0]; sh writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; sw writes all four lanes.
  - All other bytes of the word are unchanged.
  - rsp_rdata=0 and rsp_err=0.
- Loads:
  - The selected byte or halfword is shifted down to bit 0.
  - lb and lh sign-extend; lbu and lhu zero-extend; lw returns the full word.
  - A load issued after a store completes returns the stored data; there are no overlapping transactions.

Test Plan:
1. sw, addr 0x10, wdata 0x8899AABB, WAIT_CYCLES=2 -> req_ready low for 4 cycles, rsp_valid rises 3 edges after accept with rsp_err=0. Then lw 0x10 -> 0x8899AABB.
2. After test 1, loads at addr 0x13:
   - lb -> 0xFFFFFF88.
   - lbu -> 0x00000088.
   - lh at 0x12 -> 0xFFFF8899.
   - lhu at 0x10 -> 0x0000AABB.
3. sb addr 0x11 wdata 0x00000055, then lw 0x10 -> 0x889955BB. sh addr 0x12 wdata 0x1234, then lw 0x10 -> 0x123455BB.
4. lw at addr 0x11 -> rsp_err=1, rsp_rdata=0. sh at addr 0x13 -> rsp_err=1, and a following lw 0x10 is unchanged. funct3=011 load -> rsp_err=1.
5. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable and req_ready stays 0. Raise rsp_ready -> IDLE next cycle.
6. Assert rst during BUSY of an sw to 0x20 -> req_ready=1 and rsp_valid=0 next cycle, and a later lw 0x20 returns the old contents. With ADDR_WIDTH=10, sw to 0x1010 then lw 0x10 -> same data (wrap).

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the datapath load/store port and the memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory; rsp_valid rises WAIT_CYCLES+1 edges after accept.
// One transaction in flight; a response is held until rsp_ready, and no request is taken meanwhile.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int         AW        = ADDR_WIDTH + 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [31:0]     rsp_rdata_q;

  logic [31:0]     mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]      lane;
  logic [31:0]     word;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic            err_d;
  logic [3:0]      be_d;
  logic [31:0]     wdat_d;
  logic [31:0]     rdata_d;
  logic            do_access;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign do_access = (state_q == BUSY) && (cnt_q == 4'd0);

  always_comb begin
    idx      = addr_q[AW-1:2];
    lane     = addr_q[1:0];
    word     = mem[idx];
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    err_d    = 1'b0;
    be_d     = 4'b0000;
    wdat_d   = 32'h0;
    rdata_d  = 32'h0;
    case (funct3_q)
      3'b000: begin
        be_d    = 4'b0001 << lane;
        wdat_d  = {4{wdata_q[7:0]}};
        rdata_d = {{24{byte_sel[7]}}, byte_sel};
      end
      3'b001: begin
        err_d   = lane[0];
        be_d    = lane[1] ? 4'b1100 : 4'b0011;
        wdat_d  = {2{wdata_q[15:0]}};
        rdata_d = {{16{half_sel[15]}}, half_sel};
      end
      3'b010: begin
        err_d   = |lane;
        be_d    = 4'b1111;
        wdat_d  = wdata_q;
        rdata_d = word;
      end
      // Unsigned forms exist only for loads.
      3'b100: begin
        err_d   = we_q;
        rdata_d = {24'h0, byte_sel};
      end
      3'b101: begin
        err_d   = we_q | lane[0];
        rdata_d = {16'h0, half_sel};
      end
      default: err_d = 1'b1;
    endcase
    if (err_d || we_q) rdata_d = 32'h0;
    if (err_d || !we_q) be_d = 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!rst && do_access) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem[idx][8*b +: 8] <= wdat_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            funct3_q    <= bus.req_funct3;
            addr_q      <= bus.req_addr[AW-1:0];
            wdata_q     <= bus.req_wdata;
            cnt_q       <= WAIT_INIT;
            state_q     <= BUSY;
            req_ready_q <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed vector bench for dmem_responder with WAIT_CYCLES=2, ADDR_WIDTH=10.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Issue one request (caller is #1 past an edge); waits for the response and records timing.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output int low);
    wait_ready();
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    low = (bus.req_ready === 1'b0) ? 1 : 0;
    while (bus.rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (bus.req_ready === 1'b0) low++;
    end
  endtask

  task automatic handoff();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat, output int low);
    issue(we, f3, a, wd, lat, low);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    handoff();
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          low;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;

    vecs.push_back('{1'b1, 3'b010, 32'h10, 32'h8899AABB, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'h8899AABB, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF88, 1'b0});
    vecs.push_back('{1'b0, 3'b100, 32'h13, 32'h0,        32'h00000088, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8899, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 32'h10, 32'h0,        32'h0000AABB, 1'b0});
    vecs.push_back('{1'b1, 3'b000, 32'h11, 32'h00000055, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'h889955BB, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'h123455BB, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h11, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 3'b001, 32'h13, 32'h0000DEAD, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'h123455BB, 1'b0});
    vecs.push_back('{1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 3'b100, 32'h10, 32'h000000FF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 3'b110, 32'h10, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFBB, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'h11, 32'h0,        32'h00000055, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 32'h10, 32'h0,        32'h000055BB, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 32'h12, 32'h0,        32'h00001234, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 32'h11, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'h123455BB, 1'b0});

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset rsp_err",   32'(bus.rsp_err), 32'd0);

    foreach (vecs[i]) begin
      txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, low);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d ready_low", i), 32'(low), 32'd4);
      chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d idle_after", i), 32'(bus.req_ready), 32'd1);
    end

    // Response held while the consumer stalls.
    issue(1'b0, 3'b010, 32'h10, 32'h0, lat, low);
    chk("stall latency", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("stall%0d rsp_rdata", c), bus.rsp_rdata, 32'h123455BB);
      chk($sformatf("stall%0d req_ready", c), 32'(bus.req_ready), 32'd0);
    end
    handoff();
    chk("stall release rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("stall release req_ready", 32'(bus.req_ready), 32'd1);

    // Reset mid-transaction abandons the store.
    txn(1'b1, 3'b010, 32'h20, 32'h11112222, rd, er, lat, low);
    wait_ready();
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("pre-reset busy", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("abort stays idle", 32'(bus.rsp_valid), 32'd0);
    txn(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, low);
    chk("abort old contents", rd, 32'h11112222);
    chk("abort load err", 32'(er), 32'd0);

    // Upper address bits alias onto the same word.
    txn(1'b1, 3'b010, 32'h1010, 32'hCAFEF00D, rd, er, lat, low);
    chk("wrap store err", 32'(er), 32'd0);
    txn(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, low);
    chk("wrap load", rd, 32'hCAFEF00D);
    txn(1'b0, 3'b100, 32'h1013, 32'h0, rd, er, lat, low);
    chk("wrap lbu", rd, 32'h000000CA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
